// File: rtl/l2_writeback_buffer.sv
// L2 victim/writeback buffer: FIFO of dirty 256-bit lines drained as 4x64-bit memory bursts.
// Optional macro L2_WB_FORWARD_EN adds a combinational lookup of buffered lines for miss hazards.
module l2_writeback_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [31:0]  wb_addr,
    input  logic [255:0] wb_data,
    input  logic [31:0]  lookup_addr,
    output logic         lookup_hit,
    output logic [255:0] lookup_data,
    output logic         empty,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [63:0]  pmem_wdata,
    input  logic         pmem_resp
);
    // Handshake: a line is taken on any posedge where wb_valid && wb_ready; a memory
    // beat is retired on any posedge where pmem_write && pmem_resp.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_next;
    logic [1:0]       beat_cnt, beat_cnt_next;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [26:0]      addr_q [DEPTH];
    logic [255:0]     data_q [DEPTH];
    logic             push, pop;
    logic             unused_bits;

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a full buffer.
    assign wb_ready = (count != FULL_CNT);
    assign push     = wb_valid && wb_ready;
    assign pop      = (state == BURST) && pmem_resp && (beat_cnt == 2'd3);
    assign empty    = (count == '0) && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            addr_q[tail] <= wb_addr[31:5];
            data_q[tail] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next    = BURST;
                    beat_cnt_next = 2'd0;
                end
            end
            BURST: begin
                if (pmem_resp) begin
                    beat_cnt_next = beat_cnt + 2'd1;
                    if (beat_cnt == 2'd3) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst outputs are zero outside BURST; address is the head entry, stable until it pops.
    always_comb begin
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state == BURST) begin
            pmem_write   = 1'b1;
            pmem_address = {addr_q[head], 5'b0};
            pmem_wdata   = data_q[head][{beat_cnt, 6'd0} +: 64];
        end
    end

`ifdef L2_WB_FORWARD_EN
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] fwd_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            if (push) valid_q[tail] <= 1'b1;
            if (pop)  valid_q[head] <= 1'b0;
        end
    end

    // Walk oldest to newest so the last match (closest to tail) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        fwd_idx     = head;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == lookup_addr[31:5])) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[fwd_idx];
            end
        end
    end

    assign unused_bits = ^{wb_addr[4:0], lookup_addr[4:0]};
`else
    assign lookup_hit  = 1'b0;
    assign lookup_data = '0;
    assign unused_bits = ^{wb_addr[4:0], lookup_addr};
`endif

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Bench for l2_writeback_buffer: directed stimulus, expected burst beats queued and checked by a monitor.
// Build with or without L2_WB_FORWARD_EN; lookup expectations follow the macro.
module tb_l2_writeback_buffer;
    logic         clk;
    logic         reset;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic [31:0]  lookup_addr;
    logic         lookup_hit;
    logic [255:0] lookup_data;
    logic         empty;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic         pmem_resp;

    logic [95:0]  exp_q[$];
    int           n_cmp;
    int           n_err;
    int           beats_done;

    l2_writeback_buffer #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .empty        (empty),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with a burst active must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && pmem_write) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: addr=%h wdata=%h, required no burst", pmem_address, pmem_wdata);
            end else begin
                if ({pmem_address, pmem_wdata} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL beat: addr=%h wdata=%h, required addr=%h wdata=%h",
                             pmem_address, pmem_wdata, exp_q[0][95:64], exp_q[0][63:0]);
                end
                if (pmem_resp) begin
                    void'(exp_q.pop_front());
                    beats_done++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a line, wait for ready (bounded), record its four expected beats.
    task automatic push_line(input logic [31:0] a, input logic [255:0] d);
        int t;
        t = 0;
        while (!wb_ready && t < 50) begin
            next_cycle();
            t++;
        end
        if (t == 50) begin
            check("push_timeout", 256'(wb_ready), 256'(1));
            return;
        end
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        for (int i = 0; i < 4; i++) exp_q.push_back({a[31:5], 5'b0, d[64*i +: 64]});
        next_cycle();
        wb_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        int t;
        t = 0;
        while (beats_done < target && t < 100) begin
            next_cycle();
            t++;
        end
        if (t == 100) check("beat_timeout", 256'(beats_done), 256'(target));
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (!empty && t < 50) begin
            next_cycle();
            t++;
        end
        check("empty_after_drain", 256'(empty), 256'(1));
    endtask

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] line_c;
    logic [255:0] line_x;
    logic [255:0] line_y;
    int           base;

    initial begin
        n_cmp = 0;
        n_err = 0;
        beats_done = 0;
        reset = 1'b0;
        wb_valid = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        lookup_addr = '0;
        pmem_resp = 1'b0;
        line_a = {64'hAAAA_0003_0303_0303, 64'hAAAA_0002_0202_0202, 64'hAAAA_0001_0101_0101, 64'hAAAA_0000_0000_0000};
        line_b = {64'hBBBB_3333_0000_0003, 64'hBBBB_2222_0000_0002, 64'hBBBB_1111_0000_0001, 64'hBBBB_0000_0000_0000};
        line_c = {64'hCCCC_CCCC_CCCC_CCC3, 64'hCCCC_CCCC_CCCC_CCC2, 64'hCCCC_CCCC_CCCC_CCC1, 64'hCCCC_CCCC_CCCC_CCC0};
        line_x = {4{64'h5A5A_5A5A_1234_5678}};
        line_y = {4{64'hA5A5_A5A5_8765_4321}};

        // Reset state, then idle 5 cycles
        repeat (3) next_cycle();
        check("reset_wb_ready", 256'(wb_ready), 256'(1));
        check("reset_empty", 256'(empty), 256'(1));
        check("reset_pmem_write", 256'(pmem_write), 256'(0));
        check("reset_pmem_address", 256'(pmem_address), 256'(0));
        check("reset_pmem_wdata", 256'(pmem_wdata), 256'(0));
        check("reset_lookup_hit", 256'(lookup_hit), 256'(0));
        check("reset_lookup_data", lookup_data, 256'(0));
        reset = 1'b1;
        repeat (5) next_cycle();
        check("idle_wb_ready", 256'(wb_ready), 256'(1));
        check("idle_empty", 256'(empty), 256'(1));
        check("idle_pmem_write", 256'(pmem_write), 256'(0));

        // Single line, resp every cycle: address 0x1234 -> 0x1220
        pmem_resp = 1'b1;
        push_line(32'h0000_1234, line_a);
        check("busy_not_empty", 256'(empty), 256'(0));
        wait_beats(4);
        check("empty_after_4th_resp", 256'(empty), 256'(1));
        check("pmem_write_after_burst", 256'(pmem_write), 256'(0));

        // Fill with resp held low; third request must be ignored
        pmem_resp = 1'b0;
        base = beats_done;
        push_line(32'h0000_2000, line_a);
        push_line(32'h0000_3040, line_b);
        check("full_wb_ready", 256'(wb_ready), 256'(0));
        wb_valid = 1'b1;
        wb_addr  = 32'h0000_4000;
        wb_data  = line_c;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("full_hold_wb_ready", 256'(wb_ready), 256'(0));
        end
        wb_valid = 1'b0;
        pmem_resp = 1'b1;
        wait_beats(base + 4);
        check("ready_after_4_acks", 256'(wb_ready), 256'(1));
        wait_beats(base + 8);
        wait_empty();

        // Resp every other cycle: beats advance only on resp, outputs stable between
        pmem_resp = 1'b0;
        base = beats_done;
        push_line(32'h8000_00E0, line_c);
        for (int t = 0; t < 60 && beats_done < base + 4; t++) begin
            next_cycle();
            pmem_resp = ~pmem_resp;
        end
        check("alt_resp_beats", 256'(beats_done), 256'(base + 4));
        pmem_resp = 1'b0;
        next_cycle();
        next_cycle();
        check("alt_resp_empty", 256'(empty), 256'(1));

        // Duplicate address: lookup returns the newest copy
        base = beats_done;
        push_line(32'h0001_0040, line_x);
        push_line(32'h0001_0040, line_y);
        lookup_addr = 32'h0001_005F;
        #1;
`ifdef L2_WB_FORWARD_EN
        check("fwd_hit", 256'(lookup_hit), 256'(1));
        check("fwd_data_newest", lookup_data, line_y);
`else
        check("nofwd_hit", 256'(lookup_hit), 256'(0));
        check("nofwd_data", lookup_data, 256'(0));
`endif
        lookup_addr = 32'h0001_0060;
        #1;
        check("lookup_other_line_miss", 256'(lookup_hit), 256'(0));
        pmem_resp = 1'b1;
        wait_beats(base + 8);
        wait_empty();
        lookup_addr = 32'h0001_0040;
        #1;
        check("lookup_after_drain", 256'(lookup_hit), 256'(0));

        // Reset during beat 2 of a burst with a second line queued
        pmem_resp = 1'b0;
        base = beats_done;
        push_line(32'h0002_0000, line_a);
        push_line(32'h0003_0000, line_b);
        pmem_resp = 1'b1;
        wait_beats(base + 2);
        pmem_resp = 1'b0;
        check("mid_burst_write", 256'(pmem_write), 256'(1));
        #1;
        reset = 1'b0;
        #1;
        check("async_abort_write", 256'(pmem_write), 256'(0));
        check("async_abort_empty", 256'(empty), 256'(1));
        check("async_abort_ready", 256'(wb_ready), 256'(1));
        exp_q.delete();
        repeat (2) next_cycle();
        reset = 1'b1;
        pmem_resp = 1'b1;
        repeat (20) next_cycle();
        check("post_reset_no_write", 256'(pmem_write), 256'(0));
        check("post_reset_empty", 256'(empty), 256'(1));
        check("post_reset_beats", 256'(beats_done), 256'(base + 2));

        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
